// File: rtl/rv_ctl_mw_if.sv
// Control bundle between the multi-cycle RV32 controller and its datapath/memory.
// The controller uses the master view; the datapath and memory use the slave view.
interface rv_ctl_mw_if;
  logic [31:0] instr;
  logic        zero;
  logic        mem_ready;
  logic        mem_req;
  logic        mem_we;
  logic        iord;
  logic [1:0]  pcsource;
  logic        pcwrite;
  logic        pccen;
  logic        irwrite;
  logic        addrwrite;
  logic        mdrwrite;
  logic        regwen;
  logic [1:0]  wbsel;
  logic [2:0]  immsel;
  logic [1:0]  asel;
  logic        bsel;
  logic [3:0]  alusel;

  modport master (
    input  instr, zero, mem_ready,
    output mem_req, mem_we, iord, pcsource, pcwrite, pccen, irwrite,
           addrwrite, mdrwrite, regwen, wbsel, immsel, asel, bsel, alusel
  );

  modport slave (
    output instr, zero, mem_ready,
    input  mem_req, mem_we, iord, pcsource, pcwrite, pccen, irwrite,
           addrwrite, mdrwrite, regwen, wbsel, immsel, asel, bsel, alusel
  );
endinterface

// File: rtl/rv_ctl_mw.sv
// Multi-cycle RV32 subset controller: Moore FSM with a memory wait-timeout
// that traps into a sticky FAULT state, plus a retired-instruction counter.
module rv_ctl_mw #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 32,
  parameter bit          HAS_ITYPE   = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  rv_ctl_mw_if.master      bus,
  output logic [CNT_W-1:0] retired_cnt,
  output logic             fault,
  output logic [3:0]       state_o
);

  localparam int unsigned WC_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WC_W-1:0] WC_MAX = WC_W'(MEM_TIMEOUT);

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEM_ADDR  = 4'd2,
    MEM_RD    = 4'd3,
    LW_WB     = 4'd4,
    MEM_WR    = 4'd5,
    ALU_EXEC  = 4'd6,
    ALU_WB    = 4'd7,
    BR_EXEC   = 4'd8,
    JAL_EXEC  = 4'd9,
    JALR_EXEC = 4'd10,
    FAULT     = 4'd11
  } state_t;

  state_t          state, state_nxt;
  logic [WC_W-1:0] wcnt;
  logic            timeout;
  logic            retire;

  logic [6:0] op;
  logic [2:0] f3;
  logic       is_lw, is_sw, is_r, is_i, is_beq, is_bne, is_jal, is_jalr;
  logic       unused_instr_bits;

  assign op      = bus.instr[6:0];
  assign f3      = bus.instr[14:12];
  assign is_lw   = (op == 7'b0000011) && (f3 == 3'b010);
  assign is_sw   = (op == 7'b0100011) && (f3 == 3'b010);
  assign is_r    = (op == 7'b0110011);
  assign is_i    = HAS_ITYPE && (op == 7'b0010011);
  assign is_beq  = (op == 7'b1100011) && (f3 == 3'b000);
  assign is_bne  = (op == 7'b1100011) && (f3 == 3'b001);
  assign is_jal  = (op == 7'b1101111);
  assign is_jalr = (op == 7'b1100111) && (f3 == 3'b000);
  assign unused_instr_bits = ^{bus.instr[31], bus.instr[29:15], bus.instr[11:7]};

  // Timeout fires on the cycle the counter has already waited MEM_TIMEOUT cycles.
  assign timeout = (MEM_TIMEOUT != 0) && bus.mem_req && !bus.mem_ready && (wcnt == WC_MAX);

  assign retire = (state_nxt == FETCH) &&
                  (state inside {LW_WB, MEM_WR, ALU_WB, BR_EXEC, JAL_EXEC, JALR_EXEC});

  assign state_o = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= FETCH;
      wcnt        <= '0;
      retired_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (!bus.mem_req || bus.mem_ready)
        wcnt <= '0;
      else if (wcnt != WC_MAX)
        wcnt <= wcnt + 1'b1;
      if (retire)
        retired_cnt <= retired_cnt + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      FETCH: begin
        if (bus.mem_ready)  state_nxt = DECODE;
        else if (timeout)   state_nxt = FAULT;
      end
      DECODE: begin
        if (is_lw || is_sw)          state_nxt = MEM_ADDR;
        else if (is_r || is_i)       state_nxt = ALU_EXEC;
        else if (is_beq || is_bne)   state_nxt = BR_EXEC;
        else if (is_jal)             state_nxt = JAL_EXEC;
        else if (is_jalr)            state_nxt = JALR_EXEC;
        else                         state_nxt = FETCH;
      end
      MEM_ADDR:  state_nxt = is_sw ? MEM_WR : MEM_RD;
      MEM_RD: begin
        if (bus.mem_ready)  state_nxt = LW_WB;
        else if (timeout)   state_nxt = FAULT;
      end
      LW_WB:     state_nxt = FETCH;
      MEM_WR: begin
        if (bus.mem_ready)  state_nxt = FETCH;
        else if (timeout)   state_nxt = FAULT;
      end
      ALU_EXEC:  state_nxt = ALU_WB;
      ALU_WB:    state_nxt = FETCH;
      BR_EXEC:   state_nxt = FETCH;
      JAL_EXEC:  state_nxt = FETCH;
      JALR_EXEC: state_nxt = FETCH;
      FAULT:     state_nxt = FAULT;
      default:   state_nxt = FETCH;
    endcase
  end

  always_comb begin
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.iord      = 1'b0;
    bus.pcsource  = 2'd0;
    bus.pcwrite   = 1'b0;
    bus.pccen     = 1'b0;
    bus.irwrite   = 1'b0;
    bus.addrwrite = 1'b0;
    bus.mdrwrite  = 1'b0;
    bus.regwen    = 1'b0;
    bus.wbsel     = 2'd0;
    bus.immsel    = 3'd2;
    bus.asel      = 2'd0;
    bus.bsel      = 1'b0;
    bus.alusel    = 4'd0;
    fault         = 1'b0;
    unique case (state)
      FETCH: begin
        bus.mem_req = 1'b1;
        if (bus.mem_ready) begin
          bus.irwrite = 1'b1;
          bus.pccen   = 1'b1;
          bus.pcwrite = 1'b1;
        end
      end
      // Branch target is formed here so BR_EXEC can load it from the ALU register.
      DECODE: begin
        bus.asel = 2'd1;
        bus.bsel = 1'b1;
      end
      MEM_ADDR: begin
        bus.immsel    = is_sw ? 3'd1 : 3'd0;
        bus.bsel      = 1'b1;
        bus.addrwrite = 1'b1;
      end
      MEM_RD: begin
        bus.mem_req  = 1'b1;
        bus.iord     = 1'b1;
        bus.mdrwrite = bus.mem_ready;
      end
      LW_WB: begin
        bus.wbsel  = 2'd2;
        bus.regwen = 1'b1;
      end
      MEM_WR: begin
        bus.mem_req = 1'b1;
        bus.mem_we  = 1'b1;
        bus.iord    = 1'b1;
      end
      ALU_EXEC: begin
        if (is_r) begin
          bus.alusel = {f3, bus.instr[30]};
        end else begin
          bus.bsel   = 1'b1;
          bus.immsel = 3'd0;
          bus.alusel = {f3, (f3 == 3'b101) ? bus.instr[30] : 1'b0};
        end
      end
      ALU_WB: begin
        bus.wbsel  = 2'd1;
        bus.regwen = 1'b1;
      end
      BR_EXEC: begin
        bus.alusel   = 4'b0001;
        bus.pcsource = 2'd1;
        bus.pcwrite  = is_beq ? bus.zero : !bus.zero;
      end
      JAL_EXEC: begin
        bus.immsel   = 3'd3;
        bus.asel     = 2'd1;
        bus.bsel     = 1'b1;
        bus.pcsource = 2'd2;
        bus.pcwrite  = 1'b1;
        bus.regwen   = 1'b1;
      end
      JALR_EXEC: begin
        bus.immsel   = 3'd0;
        bus.bsel     = 1'b1;
        bus.pcsource = 2'd2;
        bus.pcwrite  = 1'b1;
        bus.regwen   = 1'b1;
      end
      FAULT:   fault = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_rv_ctl_mw.sv
// Directed bench for rv_ctl_mw: instance a (timeout 4, 4-bit counter, I-type on)
// and instance b (defaults with I-type off) share the same stimulus.
module tb_rv_ctl_mw;
  localparam logic [31:0] I_LW   = 32'h0000_2003;
  localparam logic [31:0] I_SW   = 32'h0000_2023;
  localparam logic [31:0] I_BEQ  = 32'h0000_0063;
  localparam logic [31:0] I_BNE  = 32'h0000_1063;
  localparam logic [31:0] I_ADD  = 32'h0000_0033;
  localparam logic [31:0] I_SUB  = 32'h4000_0033;
  localparam logic [31:0] I_ORI  = 32'h4000_6013;
  localparam logic [31:0] I_JAL  = 32'h0000_006F;
  localparam logic [31:0] I_JALR = 32'h0000_0067;
  localparam logic [31:0] I_UNK  = 32'h0000_007F;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        zero;
  logic        ready;

  logic [3:0]  ret_a;
  logic [31:0] ret_b;
  logic        fault_a, fault_b;
  logic [3:0]  state_a, state_b;

  int n_chk  = 0;
  int n_pass = 0;

  rv_ctl_mw_if ifa();
  rv_ctl_mw_if ifb();

  assign ifa.instr     = instr;
  assign ifa.zero      = zero;
  assign ifa.mem_ready = ready;
  assign ifb.instr     = instr;
  assign ifb.zero      = zero;
  assign ifb.mem_ready = ready;

  rv_ctl_mw #(.MEM_TIMEOUT(4), .CNT_W(4), .HAS_ITYPE(1'b1)) u_a (
    .clk(clk), .rst(rst), .bus(ifa.master),
    .retired_cnt(ret_a), .fault(fault_a), .state_o(state_a)
  );

  rv_ctl_mw #(.MEM_TIMEOUT(15), .CNT_W(32), .HAS_ITYPE(1'b0)) u_b (
    .clk(clk), .rst(rst), .bus(ifb.master),
    .retired_cnt(ret_b), .fault(fault_b), .state_o(state_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the controller in the state that follows DECODE for this instruction.
  task automatic fetch_decode(input logic [31:0] ins);
    instr = ins;
    ready = 1'b1;
    tick();
    ready = 1'b0;
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; instr = '0; zero = 1'b0; ready = 1'b0;
    tick(); tick();
    check("rst_state", state_a, 0);
    check("rst_cnt", ret_a, 0);
    check("rst_fault", fault_a, 0);
    rst = 1'b0; #1;
    check("rst_req_iord", {ifa.mem_req, ifa.iord}, 2'b10);

    // LW with immediate memory response
    instr = I_LW; ready = 1'b1; #1;
    check("lw_fetch", {state_a, ifa.irwrite, ifa.pccen, ifa.pcwrite, ifa.pcsource}, {4'd0, 3'b111, 2'd0});
    tick(); ready = 1'b0; #1;
    check("lw_decode", {state_a, ifa.asel, ifa.bsel, ifa.immsel, ifa.alusel, ifa.mem_req},
          {4'd1, 2'd1, 1'b1, 3'd2, 4'd0, 1'b0});
    tick();
    check("lw_addr", {state_a, ifa.immsel, ifa.asel, ifa.bsel, ifa.addrwrite},
          {4'd2, 3'd0, 2'd0, 1'b1, 1'b1});
    tick(); ready = 1'b1; #1;
    check("lw_rd", {state_a, ifa.mem_req, ifa.iord, ifa.mdrwrite, ifa.mem_we}, {4'd3, 4'b1110});
    tick(); ready = 1'b0; #1;
    check("lw_wb", {state_a, ifa.regwen, ifa.wbsel, ret_a}, {4'd4, 1'b1, 2'd2, 4'd0});
    tick();
    check("lw_retire", {state_a, ret_a}, {4'd0, 4'd1});

    // SW with mem_ready arriving on the fourth MEM_WR cycle
    fetch_decode(I_SW);
    check("sw_addr", {state_a, ifa.immsel}, {4'd5 - 4'd3, 3'd1});
    tick();
    for (int i = 0; i < 4; i++) begin
      ready = (i == 3); #1;
      check("sw_hold", {state_a, ifa.mem_req, ifa.mem_we, ifa.iord, ret_a}, {4'd5, 3'b111, 4'd1});
      tick();
    end
    ready = 1'b0; #1;
    check("sw_retire", {state_a, ret_a}, {4'd0, 4'd2});

    // Branches
    fetch_decode(I_BNE);
    zero = 1'b0; #1;
    check("bne_z0", {state_a, ifa.pcwrite, ifa.pcsource, ifa.alusel, ifa.bsel},
          {4'd8, 1'b1, 2'd1, 4'd1, 1'b0});
    tick();
    check("bne_retire", ret_a, 3);
    fetch_decode(I_BEQ);
    zero = 1'b0; #1;
    check("beq_z0", {state_a, ifa.pcwrite}, {4'd8, 1'b0});
    zero = 1'b1; #1;
    check("beq_z1", ifa.pcwrite, 1);
    tick(); zero = 1'b0;
    check("beq_retire", ret_a, 4);

    // Jumps
    fetch_decode(I_JAL);
    check("jal_exec", {state_a, ifa.immsel, ifa.asel, ifa.bsel, ifa.pcsource, ifa.pcwrite, ifa.regwen, ifa.wbsel},
          {4'd9, 3'd3, 2'd1, 1'b1, 2'd2, 1'b1, 1'b1, 2'd0});
    tick();
    check("jal_retire", ret_a, 5);
    fetch_decode(I_JALR);
    check("jalr_exec", {state_a, ifa.immsel, ifa.asel, ifa.bsel, ifa.pcsource, ifa.pcwrite, ifa.regwen},
          {4'd10, 3'd0, 2'd0, 1'b1, 2'd2, 1'b1, 1'b1});
    tick();
    check("jalr_retire", ret_a, 6);

    // Sixteen R-type instructions wrap the 4-bit counter
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      instr = (i == 0) ? I_SUB : I_ADD;
      ready = 1'b1;
      tick(); tick();
      if (i == 0) check("r_exec", {state_a, ifa.alusel, ifa.bsel, ifa.asel}, {4'd6, 4'd1, 1'b0, 2'd0});
      tick();
      if (i == 0) check("r_wb", {state_a, ifa.wbsel, ifa.regwen}, {4'd7, 2'd1, 1'b1});
      if (i == 15) check("r_cnt15", ret_a, 15);
      tick();
    end
    check("r_wrap_a", ret_a, 0);
    check("r_cnt_b", ret_b, 16);

    // Unknown opcode returns to FETCH without retiring
    instr = I_UNK; ready = 1'b1;
    tick();
    check("unk_decode", state_a, 1);
    tick();
    check("unk_fetch", {state_a, ret_a}, {4'd0, 4'd0});

    // ORI: I-type on instance a, unknown on instance b
    instr = I_ORI;
    tick(); tick();
    check("ori_exec_a", {state_a, ifa.alusel, ifa.immsel, ifa.bsel}, {4'd6, 4'b1100, 3'd0, 1'b1});
    check("ori_unk_b", state_b, 0);
    tick();
    check("ori_wb", {state_a, state_b}, {4'd7, 4'd1});
    tick();
    check("ori_retire_a", {state_a, ret_a}, {4'd0, 4'd1});
    check("ori_noret_b", {state_b, ret_b}, {4'd0, 32'd16});

    // Memory timeout in FETCH
    rst = 1'b1; tick(); rst = 1'b0; ready = 1'b0; #1;
    for (int i = 0; i < 5; i++) begin
      check("to_wait", {state_a, ifa.mem_req, fault_a}, {4'd0, 2'b10});
      tick();
    end
    check("to_fault", {state_a, fault_a, ifa.mem_req}, {4'd11, 2'b10});
    check("to_b_waiting", {state_b, fault_b}, {4'd0, 1'b0});
    ready = 1'b1;
    tick(); tick();
    check("to_sticky", {state_a, fault_a, ifa.mem_req}, {4'd11, 2'b10});
    rst = 1'b1; tick();
    check("to_rst", {state_a, fault_a}, {4'd0, 1'b0});
    rst = 1'b0; #1;
    check("to_rst_req", {ifa.mem_req, ifa.iord}, 2'b10);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
